// File: rtl/cskipa_pkg.sv
// cskipa_pkg: shared FSM state type, slice width and slice-count helpers for the carry-skip subtractor
package cskipa_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int SLICE_W = 4;
    function automatic int num_slices(input int width);
        return (width + SLICE_W - 1) / SLICE_W;
    endfunction
    function automatic int top_slice_w(input int width);
        return (width % SLICE_W == 0) ? SLICE_W : width % SLICE_W;
    endfunction
endpackage

// File: rtl/cskip_sub_slice.sv
// cskip_sub_slice: W-bit carry-skip slice (a, b_n, cin -> sum, cout), skip mux bypasses ripple when all bits propagate
module cskip_sub_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b_n,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W-1:0] p, g;
    logic         rip;
    assign p = a ^ b_n;
    assign g = a & b_n;
    always_comb begin
        logic c;
        c = cin;
        sum = '0;
        for (int i = 0; i < W; i++) begin
            sum[i] = p[i] ^ c;
            c = g[i] | (p[i] & c);
        end
        rip = c;
    end
    assign cout = &p ? cin : rip;
endmodule

// File: rtl/cskipa_sub_seq_25bit.sv
// cskipa_sub_seq_25bit: A-B one 4-bit carry-skip slice per cycle; valid/ready in (i_valid/o_ready, i_minuend, i_subtrahend) and out (o_valid/i_ready, o_diff, o_borrow)
module cskipa_sub_seq_25bit
    import cskipa_pkg::*;
#(
    parameter int WIDTH = 25
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_minuend,
    input  logic [WIDTH-1:0] i_subtrahend,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow
);
    localparam int NS    = num_slices(WIDTH);
    localparam int TOP_W = top_slice_w(WIDTH);
    localparam int PW    = NS * SLICE_W;
    localparam int KW    = NS > 1 ? $clog2(NS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NS - 1);
    state_t             state, state_n;
    logic [KW-1:0]      k;
    logic [WIDTH-1:0]   a, b_n, diff_n;
    logic [PW-1:0]      a_pad, b_pad;
    logic [SLICE_W-1:0] sum;
    logic [SLICE_W:0]   ext;
    logic               carry, cout, last, accept;
    assign a_pad   = PW'(a);
    assign b_pad   = PW'(b_n);
    assign ext     = {cout, sum};
    assign last    = k == K_LAST;
    assign o_ready = state == IDLE;
    assign o_valid = state == DONE;
    assign accept  = i_valid && o_ready;
    cskip_sub_slice #(.W(SLICE_W)) u_slice (
        .a   (a_pad[int'(k) * SLICE_W +: SLICE_W]),
        .b_n (b_pad[int'(k) * SLICE_W +: SLICE_W]),
        .cin (carry),
        .sum (sum),
        .cout(cout)
    );
    always_comb begin
        diff_n = o_diff;
        for (int i = 0; i < WIDTH; i++)
            if (i / SLICE_W == int'(k)) diff_n[i] = sum[i % SLICE_W];
    end
    always_comb begin
        state_n = (state == IDLE && i_valid) ? RUN :
                  (state == RUN && last)     ? DONE :
                  (state == DONE && i_ready) ? IDLE : state;
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= IDLE;
        else state <= state_n;
    end
    // The top slice has zero-padded inputs above the real MSB, so the carry out of
    // bit WIDTH-1 shows up as the sum bit just above it (or as cout for a full slice).
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            a        <= '0;
            b_n      <= '0;
            carry    <= 1'b0;
            k        <= '0;
            o_diff   <= '0;
            o_borrow <= 1'b0;
        end else if (accept) begin
            a        <= i_minuend;
            b_n      <= ~i_subtrahend;
            carry    <= 1'b1;
            k        <= '0;
            o_diff   <= '0;
            o_borrow <= 1'b0;
        end else if (state == RUN) begin
            o_diff <= diff_n;
            carry  <= cout;
            k      <= last ? '0 : k + 1'b1;
            if (last) o_borrow <= ~ext[TOP_W];
        end
    end
endmodule

// File: tb/tb_cskipa_sub_seq_25bit.sv
// tb_cskipa_sub_seq_25bit: directed and randomized checks of the sequential carry-skip subtractor against A-B / A<B
module tb_cskipa_sub_seq_25bit;
    logic        clk = 1'b0;
    logic        rst_n, i_valid, i_ready, o_ready, o_valid, o_borrow;
    logic [24:0] a_in, b_in, o_diff;
    logic [3:0]  sa, sb, ss;
    logic        sc, sco, s1a, s1b, s1c, s1s, s1co;
    int          errors = 0;
    int          checks = 0;
    always #5 clk = ~clk;
    cskipa_sub_seq_25bit dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_minuend(a_in), .i_subtrahend(b_in), .o_valid(o_valid), .i_ready(i_ready),
        .o_diff(o_diff), .o_borrow(o_borrow)
    );
    cskip_sub_slice #(.W(4)) u_s4 (.a(sa), .b_n(sb), .cin(sc), .sum(ss), .cout(sco));
    cskip_sub_slice #(.W(1)) u_s1 (.a(s1a), .b_n(s1b), .cin(s1c), .sum(s1s), .cout(s1co));
    function automatic logic [25:0] ref_sub(input logic [24:0] a, input logic [24:0] b);
        logic [24:0] d;
        d = a - b;
        return {a < b, d};
    endfunction
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic do_op(input logic [24:0] a, input logic [24:0] b, input logic rdy,
                         output logic [24:0] d, output logic bw, output int lat);
        a_in = a; b_in = b; i_valid = 1'b1; i_ready = rdy;
        lat = 0;
        tick;
        i_valid = 1'b0;
        while (!o_valid && lat < 20) begin
            tick;
            lat++;
        end
        d = o_diff; bw = o_borrow;
        i_ready = 1'b1;
        tick;
        i_ready = 1'b0;
    endtask
    task automatic test_reset;
        rst_n = 1'b0; i_valid = 1'b1; i_ready = 1'b0; a_in = 25'($urandom); b_in = 25'($urandom);
        tick;
        tick;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
        checks++; if (o_diff !== 25'd0) begin errors++; $display("FAIL reset_diff got=%h exp=0", o_diff); end
        checks++; if (o_borrow !== 1'b0) begin errors++; $display("FAIL reset_borrow got=%b exp=0", o_borrow); end
        i_valid = 1'b0; rst_n = 1'b1;
        tick;
    endtask
    task automatic test_basic;
        logic [24:0] d; logic bw; int lat;
        do_op(25'd100, 25'd37, 1'b1, d, bw, lat);
        checks++; if (lat != 7) begin errors++; $display("FAIL basic_latency got=%0d exp=7", lat); end
        checks++; if (d !== 25'd63) begin errors++; $display("FAIL basic_diff got=%0d exp=63", d); end
        checks++; if (bw !== 1'b0) begin errors++; $display("FAIL basic_borrow got=%b exp=0", bw); end
        checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("FAIL basic_release valid=%b ready=%b exp 0/1", o_valid, o_ready); end
    endtask
    task automatic test_wrap;
        logic [24:0] av[2], bv[2], dv[2]; logic bwv[2];
        logic [24:0] d; logic bw; int lat;
        av = '{25'd0, 25'h1FFFFFF}; bv = '{25'd1, 25'd0};
        dv = '{25'h1FFFFFF, 25'h1FFFFFF}; bwv = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            do_op(av[i], bv[i], 1'b0, d, bw, lat);
            checks++; if (d !== dv[i]) begin errors++; $display("FAIL wrap_diff[%0d] got=%h exp=%h", i, d, dv[i]); end
            checks++; if (bw !== bwv[i]) begin errors++; $display("FAIL wrap_borrow[%0d] got=%b exp=%b", i, bw, bwv[i]); end
        end
    endtask
    task automatic test_skip;
        logic [24:0] av[2], bv[2], dv[2];
        logic [24:0] d; logic bw; int lat;
        av = '{25'h1555555, 25'h1000000}; bv = '{25'h1555555, 25'd1};
        dv = '{25'd0, 25'h0FFFFFF};
        for (int i = 0; i < 2; i++) begin
            do_op(av[i], bv[i], 1'b1, d, bw, lat);
            checks++; if (d !== dv[i]) begin errors++; $display("FAIL skip_diff[%0d] got=%h exp=%h", i, d, dv[i]); end
            checks++; if (bw !== 1'b0) begin errors++; $display("FAIL skip_borrow[%0d] got=%b exp=0", i, bw); end
        end
    endtask
    task automatic test_backpressure;
        logic [24:0] d; logic bw; int n;
        a_in = 25'd500; b_in = 25'd800; i_valid = 1'b1; i_ready = 1'b0;
        tick;
        i_valid = 1'b0;
        tick;
        tick;
        a_in = 25'($urandom); b_in = 25'($urandom); i_valid = 1'b1;
        n = 0;
        while (!o_valid && n < 20) begin
            tick;
            n++;
        end
        d = o_diff; bw = o_borrow;
        checks++; if (d !== 25'h1FFFED4) begin errors++; $display("FAIL bp_diff got=%h exp=1fffed4", d); end
        checks++; if (bw !== 1'b1) begin errors++; $display("FAIL bp_borrow got=%b exp=1", bw); end
        for (int i = 0; i < 5; i++) begin
            tick;
            checks++;
            if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_diff !== d || o_borrow !== bw) begin
                errors++;
                $display("FAIL bp_hold[%0d] valid=%b ready=%b diff=%h borrow=%b exp 1/0/%h/%b", i, o_valid, o_ready, o_diff, o_borrow, d, bw);
            end
        end
        i_valid = 1'b0; i_ready = 1'b1;
        tick;
        i_ready = 1'b0;
        checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("FAIL bp_release valid=%b ready=%b exp 0/1", o_valid, o_ready); end
    endtask
    task automatic test_reset_mid;
        logic [24:0] d; logic bw; int lat;
        a_in = 25'h0ABCDEF; b_in = 25'h0012345; i_valid = 1'b1; i_ready = 1'b0;
        tick;
        i_valid = 1'b0;
        tick;
        tick;
        tick;
        rst_n = 1'b0;
        tick;
        checks++;
        if (o_valid !== 1'b0 || o_diff !== 25'd0 || o_borrow !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort valid=%b diff=%h borrow=%b ready=%b exp 0/0/0/1", o_valid, o_diff, o_borrow, o_ready);
        end
        rst_n = 1'b1;
        do_op(25'd7, 25'd9, 1'b1, d, bw, lat);
        checks++; if (d !== 25'h1FFFFFE) begin errors++; $display("FAIL abort_next_diff got=%h exp=1fffffe", d); end
        checks++; if (bw !== 1'b1) begin errors++; $display("FAIL abort_next_borrow got=%b exp=1", bw); end
        checks++; if (lat != 7) begin errors++; $display("FAIL abort_next_latency got=%0d exp=7", lat); end
    endtask
    task automatic test_random;
        logic [25:0] q[$];
        logic [25:0] exp;
        int done_n = 0;
        int cyc = 0;
        while (done_n < 1500 && cyc < 40000) begin
            i_valid = 1'($urandom_range(0, 1));
            i_ready = $urandom_range(0, 3) != 0;
            a_in = 25'($urandom);
            b_in = ($urandom_range(0, 7) == 0) ? a_in : 25'($urandom);
            checks++; if (o_valid && o_ready) begin errors++; $display("FAIL rand_proto valid and ready both high at cycle %0d", cyc); end
            if (o_valid && i_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_unexpected result diff=%h with no pending op", o_diff);
                end else begin
                    exp = q.pop_front();
                    if ({o_borrow, o_diff} !== exp) begin
                        errors++;
                        $display("FAIL rand_result[%0d] got=%b/%h exp=%b/%h", done_n, o_borrow, o_diff, exp[25], exp[24:0]);
                    end
                end
                done_n++;
            end
            if (i_valid && o_ready) q.push_back(ref_sub(a_in, b_in));
            tick;
            cyc++;
        end
        i_valid = 1'b0; i_ready = 1'b0;
        checks++; if (done_n != 1500) begin errors++; $display("FAIL rand_timeout completed=%0d exp=1500", done_n); end
    endtask
    task automatic test_slice_exhaustive;
        logic [4:0] e4;
        logic [1:0] e1;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++) begin
                    sa = 4'(a); sb = 4'(b); sc = 1'(c);
                    #1;
                    e4 = 5'(a + b + c);
                    checks++;
                    if ({sco, ss} !== e4) begin errors++; $display("FAIL slice4 a=%0d b=%0d c=%0d got=%b exp=%b", a, b, c, {sco, ss}, e4); end
                end
        for (int v = 0; v < 8; v++) begin
            s1a = 1'(v); s1b = 1'(v >> 1); s1c = 1'(v >> 2);
            #1;
            e1 = 2'(s1a) + 2'(s1b) + 2'(s1c);
            checks++;
            if ({s1co, s1s} !== e1) begin errors++; $display("FAIL slice1 v=%0d got=%b exp=%b", v, {s1co, s1s}, e1); end
        end
    endtask
    initial begin
        rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0; a_in = '0; b_in = '0;
        sa = '0; sb = '0; sc = 1'b0; s1a = 1'b0; s1b = 1'b0; s1c = 1'b0;
        test_reset;
        test_basic;
        test_wrap;
        test_skip;
        test_backpressure;
        test_reset_mid;
        test_random;
        test_slice_exhaustive;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
